// File: rtl/mac_acc_b.sv
// mac_acc_b: address-grouped signed fixed-point multiply-accumulate.
//
// Each enabled cycle, the block multiplies i_a by i_b and adds the product to a running sum. The
// sum keeps growing while i_addr stays the same. When the address changes, or a flush arrives on
// an idle cycle, the block closes the group. It emits the sum rescaled by FRAC bits and saturated
// to WIDTH bits, tagged with the address of the group.
//
// Ports:
//   clk      in   rising-edge clock
//   rst      in   asynchronous active-low reset
//   en       in   sample i_a, i_b, i_addr this cycle
//   i_addr   in   address of the current term
//   i_a      in   signed operand, Q(WIDTH-FRAC).FRAC
//   i_b      in   signed operand, Q(WIDTH-FRAC).FRAC
//   flush    in   close the open group (ignored while en=1)
//   o_valid  out  one-cycle pulse qualifying o_addr/o_data/o_count/o_sat
//   o_addr   out  address of the emitted group
//   o_data   out  rescaled, saturated group sum
//   o_count  out  number of terms in the group (wraps)
//   o_sat    out  o_data was clamped
//   o_busy   out  a group is open
module mac_acc_b #(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned FRAC       = 12,
    parameter int unsigned ACC_WIDTH  = 40,
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [WIDTH-1:0]      i_a,
    input  logic [WIDTH-1:0]      i_b,
    input  logic                  flush,
    output logic                  o_valid,
    output logic [ADDR_WIDTH-1:0] o_addr,
    output logic [WIDTH-1:0]      o_data,
    output logic [CNT_WIDTH-1:0]  o_count,
    output logic                  o_sat,
    output logic                  o_busy
);

    localparam int unsigned PW = 2 * WIDTH;

    // Saturation bounds expressed at accumulator width so the comparison is exact.
    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
        (ACC_WIDTH'(1) << (WIDTH - 1)) - ACC_WIDTH'(1);
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ~SAT_MAX;

    // Stage 1 registers
    logic                  v1;
    logic                  f1;
    logic [PW-1:0]         p1;
    logic [ADDR_WIDTH-1:0] a1;

    // Stage 2 state
    logic [ACC_WIDTH-1:0]  acc;
    logic [ADDR_WIDTH-1:0] cur;
    logic [CNT_WIDTH-1:0]  cnt;
    logic                  have;

    logic [PW-1:0]                prod;
    logic signed [ACC_WIDTH-1:0]  p1_ext;
    logic signed [ACC_WIDTH-1:0]  shifted;
    logic                         sat_hi;
    logic                         sat_lo;
    logic [WIDTH-1:0]             clamped;

    // Sign-extend both operands to the product width. An unsigned multiply then gives the
    // correct two's-complement product modulo 2^PW.
    always_comb begin
        prod = {{WIDTH{i_a[WIDTH-1]}}, i_a} * {{WIDTH{i_b[WIDTH-1]}}, i_b};
    end

    always_comb begin
        p1_ext  = ACC_WIDTH'($signed(p1));
        shifted = $signed(acc) >>> FRAC;
        sat_hi  = shifted > SAT_MAX;
        sat_lo  = shifted < SAT_MIN;
        if (sat_hi) begin
            clamped = {1'b0, {(WIDTH - 1){1'b1}}};
        end else if (sat_lo) begin
            clamped = {1'b1, {(WIDTH - 1){1'b0}}};
        end else begin
            clamped = shifted[WIDTH-1:0];
        end
    end

    // Stage 1: capture the term. A flush that arrives together with a term is dropped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v1 <= 1'b0;
            f1 <= 1'b0;
            p1 <= '0;
            a1 <= '0;
        end else begin
            v1 <= en;
            f1 <= flush & ~en;
            if (en) begin
                p1 <= prod;
                a1 <= i_addr;
            end
        end
    end

    // Stage 2: group the terms and emit. The emit paths read acc, cur and cnt before this edge
    // updates them, so a closing group is reported with its own totals.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc     <= '0;
            cur     <= '0;
            cnt     <= '0;
            have    <= 1'b0;
            o_valid <= 1'b0;
            o_addr  <= '0;
            o_data  <= '0;
            o_count <= '0;
            o_sat   <= 1'b0;
        end else begin
            o_valid <= 1'b0;
            if (v1) begin
                if (have && (a1 == cur)) begin
                    acc <= acc + p1_ext;
                    cnt <= cnt + CNT_WIDTH'(1);
                end else begin
                    if (have) begin
                        o_valid <= 1'b1;
                        o_addr  <= cur;
                        o_count <= cnt;
                        o_data  <= clamped;
                        o_sat   <= sat_hi | sat_lo;
                    end
                    acc  <= p1_ext;
                    cur  <= a1;
                    cnt  <= CNT_WIDTH'(1);
                    have <= 1'b1;
                end
            end else if (f1 && have) begin
                o_valid <= 1'b1;
                o_addr  <= cur;
                o_count <= cnt;
                o_data  <= clamped;
                o_sat   <= sat_hi | sat_lo;
                have    <= 1'b0;
                acc     <= '0;
                cnt     <= '0;
            end
        end
    end

    assign o_busy = have;

endmodule

// File: tb/tb_mac_acc_b.sv
// Self-checking bench for mac_acc_b. A group-level model predicts every output on every cycle. A
// literal table pins the groups the model itself must have emitted.
module tb_mac_acc_b;

    logic        clk;
    logic        rst;
    logic        en;
    logic [11:0] i_addr;
    logic [15:0] i_a;
    logic [15:0] i_b;
    logic        flush;
    logic        o_valid;
    logic [11:0] o_addr;
    logic [15:0] o_data;
    logic [7:0]  o_count;
    logic        o_sat;
    logic        o_busy;

    int total = 0;
    int bad   = 0;

    mac_acc_b dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .i_addr  (i_addr),
        .i_a     (i_a),
        .i_b     (i_b),
        .flush   (flush),
        .o_valid (o_valid),
        .o_addr  (o_addr),
        .o_data  (o_data),
        .o_count (o_count),
        .o_sat   (o_sat),
        .o_busy  (o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: an open group is just (address, exact sum, term count).
    bit          m_have;
    logic [11:0] m_addr;
    longint      m_sum;
    int          m_cnt;
    bit          x_valid;
    logic [11:0] x_addr;
    logic [15:0] x_data;
    logic [7:0]  x_count;
    bit          x_sat;
    // The term presented at the previous edge takes effect at this edge.
    bit          p_en;
    bit          p_fl;
    logic [11:0] p_addr;
    longint      p_prod;
    // History of groups closed by the model, checked against hand-computed values.
    logic [11:0] h_addr[$];
    int          h_data[$];
    int          h_cnt[$];
    bit          h_sat[$];
    int          dut_emits = 0;

    function automatic void model_emit();
        longint q;
        q       = m_sum >>> 12;
        x_valid = 1'b1;
        x_addr  = m_addr;
        x_count = 8'(m_cnt);
        x_sat   = (q > 32767) || (q < -32768);
        if (q > 32767) q = 32767;
        if (q < -32768) q = -32768;
        x_data = 16'(q);
        h_addr.push_back(m_addr);
        h_data.push_back(int'(q));
        h_cnt.push_back(m_cnt);
        h_sat.push_back(x_sat);
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            x_valid = 1'b0;
            if (!rst) begin
                m_have = 0; m_addr = 0; m_sum = 0; m_cnt = 0;
                x_addr = 0; x_data = 0; x_count = 0; x_sat = 0;
                p_en = 0; p_fl = 0; p_addr = 0; p_prod = 0;
            end else begin
                if (p_en) begin
                    if (m_have && p_addr == m_addr) begin
                        m_sum = m_sum + p_prod;
                        m_cnt = m_cnt + 1;
                    end else begin
                        if (m_have) model_emit();
                        m_have = 1; m_addr = p_addr; m_sum = p_prod; m_cnt = 1;
                    end
                    // The accumulator is 40 bits wide and wraps.
                    m_sum = (m_sum <<< 24) >>> 24;
                end else if (p_fl && m_have) begin
                    model_emit();
                    m_have = 0; m_sum = 0; m_cnt = 0;
                end
                p_en   = en;
                p_fl   = flush && !en;
                p_addr = i_addr;
                if (en) p_prod = longint'($signed(i_a)) * longint'($signed(i_b));
            end
            #1;
            chk("o_valid", 32'(o_valid), 32'(x_valid));
            chk("o_busy", 32'(o_busy), 32'(m_have));
            chk("o_addr", 32'(o_addr), 32'(x_addr));
            chk("o_data", 32'(o_data), 32'(x_data));
            chk("o_count", 32'(o_count), 32'(x_count));
            chk("o_sat", 32'(o_sat), 32'(x_sat));
            if (o_valid) dut_emits++;
        end
    end

    task automatic step(input logic e, input logic f, input logic [11:0] ad,
                        input logic [15:0] a, input logic [15:0] b);
        @(negedge clk);
        en = e; flush = f; i_addr = ad; i_a = a; i_b = b;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 12'd0, 16'd0, 16'd0);
    endtask

    localparam logic [15:0] ONE  = 16'd4096;
    localparam logic [15:0] TWO  = 16'd8192;
    localparam logic [15:0] MAXV = 16'h7fff;
    localparam logic [15:0] MINV = 16'h8000;
    localparam logic [15:0] NEG1 = 16'hf000;

    // Hand-computed groups, in emit order.
    logic [11:0] l_addr[8] = '{12'd0, 12'd1, 12'd5, 12'd2, 12'd2, 12'd3, 12'd9, 12'd8};
    int          l_data[8] = '{24576, 4096, -4096, 32767, -32768, 12288, 4096, 4096};
    int          l_cnt[8]  = '{3, 1, 2, 2, 2, 3, 1, 1};
    bit          l_sat[8]  = '{0, 0, 0, 1, 1, 0, 0, 0};

    initial begin
        rst = 1'b0; en = 0; flush = 0; i_addr = 0; i_a = 0; i_b = 0;
        idle(3);
        @(negedge clk) rst = 1'b1;
        idle(1);
        // Close on address change, then flush the last group.
        step(1, 0, 12'd0, ONE, TWO);
        step(1, 0, 12'd0, ONE, TWO);
        step(1, 0, 12'd0, ONE, TWO);
        step(1, 0, 12'd1, ONE, ONE);
        idle(2);
        step(0, 1, 12'd0, 0, 0);
        idle(2);
        // Sign handling and floor truncation.
        step(1, 0, 12'd5, NEG1, ONE);
        step(1, 0, 12'd5, 16'd1, 16'd1);
        step(0, 1, 12'd0, 0, 0);
        idle(2);
        // Positive and negative saturation.
        step(1, 0, 12'd2, MAXV, MAXV);
        step(1, 0, 12'd2, MAXV, MAXV);
        step(0, 1, 12'd0, 0, 0);
        step(1, 0, 12'd2, MINV, MAXV);
        step(1, 0, 12'd2, MINV, MAXV);
        step(0, 1, 12'd0, 0, 0);
        idle(2);
        // Gaps in en leave the group open.
        step(1, 0, 12'd3, ONE, ONE);
        idle(2);
        step(1, 0, 12'd3, ONE, ONE);
        step(1, 0, 12'd3, ONE, ONE);
        step(0, 1, 12'd0, 0, 0);
        idle(2);
        // A flush that arrives with en=1 is dropped. A flush with no open group does nothing.
        step(1, 1, 12'd9, ONE, ONE);
        idle(2);
        step(0, 1, 12'd0, 0, 0);
        step(0, 1, 12'd0, 0, 0);
        idle(2);
        // Reset in the middle of a group discards it.
        step(1, 0, 12'd7, ONE, ONE);
        step(1, 0, 12'd7, ONE, ONE);
        idle(1);
        @(negedge clk) rst = 1'b0;
        #1;
        chk("rst_async_busy", 32'(o_busy), 32'd0);
        chk("rst_async_valid", 32'(o_valid), 32'd0);
        chk("rst_async_data", 32'(o_data), 32'd0);
        chk("rst_async_addr", 32'(o_addr), 32'd0);
        idle(2);
        @(negedge clk) rst = 1'b1;
        step(1, 0, 12'd8, ONE, ONE);
        step(0, 1, 12'd0, 0, 0);
        idle(3);

        chk("model_emits", 32'(h_addr.size()), 32'd8);
        chk("dut_emits", 32'(dut_emits), 32'd8);
        for (int i = 0; i < 8; i++) begin
            if (i < h_addr.size()) begin
                chk("lit_addr", 32'(h_addr[i]), 32'(l_addr[i]));
                chk("lit_data", 32'(h_data[i]), 32'(l_data[i]));
                chk("lit_count", 32'(h_cnt[i]), 32'(l_cnt[i]));
                chk("lit_sat", 32'(h_sat[i]), 32'(l_sat[i]));
            end
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mac_acc_b.md
# mac_acc_b

Address-grouped multiply-accumulate stage sitting directly downstream of the backward-pass address generator in the LSTM training path. Each enabled cycle it multiplies two signed fixed-point operands and accumulates the products while the incoming address is unchanged. When the address changes, or on an explicit flush, it emits the rescaled, saturated sum tagged with the address it belongs to. The result feeds the gradient write-back to weight/bias memory.

## Interface
- WIDTH, 16: operand and result width, signed two's complement.
- FRAC, 12: fractional bits of operands and result.
- ACC_WIDTH, 40: internal accumulator width; must be ≥ 2*WIDTH.
- ADDR_WIDTH, 12: address width; matches the address generator.
- CNT_WIDTH, 8: term-counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; asynchronous assert, active-low.
- en  in  1  sample i_a, i_b and i_addr this cycle.
- i_addr  in  ADDR_WIDTH  address of the current term, driven by the address generator.
- i_a  in  WIDTH  signed operand.
- i_b  in  WIDTH  signed operand.
- flush  in  1  close the open group; honoured only when en=0.
- o_valid  out  1  one-cycle pulse: o_addr, o_data, o_count and o_sat are valid.
- o_addr  out  ADDR_WIDTH  address of the emitted group.
- o_data  out  WIDTH  saturated sum, Q(WIDTH-FRAC).FRAC.
- o_count  out  CNT_WIDTH  number of terms in the group; wraps modulo 2^CNT_WIDTH.
- o_sat  out  1  o_data was clamped.
- o_busy  out  1  a group is open (have=1).

## Operation
- Reset (rst=0), asynchronous: all registers and outputs clear to 0, including o_valid, o_addr, o_data, o_count, o_sat and o_busy. The pipeline is emptied and any open group is discarded without emission.
- Stage 1 (registered):
  - v1 <= en.
  - If en=1: p1 <= i_a*i_b (full 2*WIDTH signed) and a1 <= i_addr.
  - f1 <= flush & ~en; flush together with en=1 is ignored.
- Stage 2 state: acc (ACC_WIDTH), cur (ADDR_WIDTH), cnt (CNT_WIDTH), have (1 bit).
- Stage 2 actions on each edge; o_valid defaults to 0:
  - v1 & ~have: acc <= sext(p1); cur <= a1; cnt <= 1; have <= 1.
  - v1 & have & a1==cur: acc <= acc+sext(p1); cnt <= cnt+1.
  - v1 & have & a1!=cur: emit (cur, acc, cnt); then acc <= sext(p1), cur <= a1, cnt <= 1.
  - f1 & have: emit (cur, acc, cnt); have <= 0, acc <= 0, cnt <= 0.
  - f1 & ~have: no action, no pulse.
  - v1 and f1 are mutually exclusive by construction.
- Emit: o_valid <= 1 and o_addr <= cur; o_count <= cnt; o_data <= clamp(acc >>> FRAC). The shift is arithmetic (floor).
- Clamp range: [-2^(WIDTH-1), 2^(WIDTH-1)-1]. o_sat <= 1 iff clamped. acc itself wraps modulo 2^ACC_WIDTH with no detection.
- en=0 gaps with flush=0 leave the open group untouched for any length of time.
- Output registers hold their last emitted values until the next emit; only o_valid drops.

## Timing
- Term sampled at edge E0 enters the accumulator at E1. Latency 1 for accumulation.
- First term of a new address sampled at E0 closes the previous group: o_valid is high between E1 and E2.
- Flush sampled at E0 (en=0) gives o_valid high between E1 and E2.
- Back-to-back address changes every cycle emit on consecutive cycles. Throughput: 1 term per cycle, up to 1 emit per cycle.
- o_busy reflects `have` after each edge.
- Reset deasserted mid-group: the first sample after release starts a fresh group. No stale emit.

## Test plan
- Group close on address change: WIDTH=16, FRAC=12. Addr 0 with a=4096, b=8192 for 3 cycles, then addr 1 with a=b=4096 -> pulse o_addr=0, o_data=24576, o_count=3, o_sat=0. A later flush -> o_addr=1, o_data=4096, o_count=1.
- Sign and truncation: addr 5, a=-4096, b=4096, then a=1, b=1, then flush -> o_data=-4096, o_count=2. The term 1*1=1 floors to 0.
- Saturation: a=b=32767 twice on addr 2, then flush -> o_data=32767, o_sat=1. Same test with a=-32768, b=32767 -> o_data=-32768, o_sat=1.
- Gaps and flush rules:
  - en toggling 1,0,0,1,1 on addr 3 with a=b=4096 -> a single emit with o_count=3, o_data=12288.
  - flush asserted with en=1 -> no pulse.
  - flush with no open group -> no pulse.
- Reset mid-group: accumulate 2 terms on addr 7, pulse rst=0 -> all outputs 0, o_busy=0. Then addr 8 with one term and a flush -> o_addr=8, o_count=1.
